// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot, I-cache miss wait with timeout, branch redirect and
// interrupt/bus-error vectoring. Drives the PC source select and the PC enable.
module fetch_ctrl #(
    parameter int unsigned MISS_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hzstallF,
    input  logic        branchD,
    input  logic        imissF,
    input  logic        ireadyF,
    input  logic        irq,
    input  logic        ieD,
    input  logic        eretD,
    input  logic [31:0] pcF,
    output logic [1:0]  pcsrcFD,
    output logic        stallF,
    output logic        missstallF,
    output logic        flushD,
    output logic        intackF,
    output logic        ibuserrF,
    output logic [31:0] epcF
);

    localparam logic [1:0] PcSrcReset  = 2'b00;
    localparam logic [1:0] PcSrcVector = 2'b01;
    localparam logic [1:0] PcSrcPlus4  = 2'b10;
    localparam logic [1:0] PcSrcBranch = 2'b11;

    localparam logic [CNT_W-1:0] MissLast = CNT_W'(MISS_TIMEOUT - 1);

    typedef enum logic [1:0] {StBoot, StRun, StMiss, StVec} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_handler_q, in_handler_d;
    logic             errflag_q, errflag_d;
    logic [31:0]      epc_d;
    logic             run_eval;
    logic             take_irq;

    assign take_irq = irq & ieD & ~in_handler_q & ~hzstallF;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_handler_d = in_handler_q;
        errflag_d    = errflag_q;
        epc_d        = epcF;
        pcsrcFD      = PcSrcPlus4;
        stallF       = 1'b0;
        missstallF   = 1'b0;
        flushD       = 1'b0;
        intackF      = 1'b0;
        ibuserrF     = 1'b0;
        run_eval     = 1'b0;

        if (eretD && state_q != StBoot) begin
            in_handler_d = 1'b0;
            errflag_d    = 1'b0;
        end

        unique case (state_q)
            StBoot: begin
                pcsrcFD = PcSrcReset;
                flushD  = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                run_eval = 1'b1;
            end
            StMiss: begin
                cnt_d = cnt_q + 1'b1;
                if (ireadyF) begin
                    run_eval = 1'b1;
                end else begin
                    stallF     = 1'b1;
                    missstallF = 1'b1;
                    if (cnt_q == MissLast) begin
                        ibuserrF  = 1'b1;
                        epc_d     = pcF;
                        errflag_d = 1'b1;
                        state_d   = StVec;
                    end
                end
            end
            StVec: begin
                pcsrcFD      = PcSrcVector;
                flushD       = 1'b1;
                intackF      = 1'b1;
                in_handler_d = 1'b1;
                state_d      = StRun;
            end
            default: state_d = StBoot;
        endcase

        // Refill completion falls straight into the normal run rules; the miss it
        // satisfies is not re-raised in the same cycle.
        if (run_eval) begin
            state_d = StRun;
            if (imissF && state_q == StRun) begin
                stallF     = 1'b1;
                missstallF = 1'b1;
                cnt_d      = '0;
                state_d    = StMiss;
            end else if (take_irq && !branchD) begin
                epc_d   = pcF;
                state_d = StVec;
            end else if (hzstallF) begin
                stallF = 1'b1;
            end else if (branchD) begin
                // A pending interrupt waits one cycle so epc captures the branch target.
                pcsrcFD = PcSrcBranch;
                flushD  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StBoot;
            cnt_q        <= '0;
            in_handler_q <= 1'b0;
            errflag_q    <= 1'b0;
            epcF         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_handler_q <= in_handler_d;
            errflag_q    <= errflag_d;
            epcF         <= epc_d;
        end
    end

endmodule
